cobs_encode_pp: RTL and testbench

Parametrised, double-buffered COBS frame encoder. It accepts raw byte frames on a valid/ready/last input stream and emits fully COBS-encoded frames on an output stream, optionally terminated by a 0x00 delimiter. Input and output run concurrently: a new frame is written into one bank while the previous encoded frame drains from the other. The block sits in the framework layer between packet sources and the byte-serial link transmitter, and handles full-spec COBS, including 254-byte non-zero runs.

---
 rtl/cobs_encode_pp.sv | 236 +++++++++++++++++++++++
 tb/tb_cobs_encode_pp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cobs_encode_pp.sv
// cobs_encode_pp: double-buffered COBS frame encoder.
// One bank fills from the raw stream while the other drains encoded bytes.
module cobs_encode_pp #(
  parameter int MAX_FRAME    = 1024,
  parameter bit APPEND_DELIM = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_last,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_drop
);

  localparam int BANK_DEPTH = MAX_FRAME + (MAX_FRAME + 253) / 254 + 1;
  localparam int PW = $clog2(BANK_DEPTH + 1);
  localparam int MW = $clog2(2 * BANK_DEPTH);

  typedef enum logic [2:0] {
    IDLE, RUN, CLOSE255, FINAL_CODE, DELIM, WAIT_BANK
  } wr_st_e;

  wr_st_e        st_q, st_d;
  logic          wbank_q, wbank_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] cslot_q, cslot_d;
  logic [7:0]    code_q, code_d;
  logic          closed_q, closed_d;
  logic          ovf_q, ovf_d;
  logic          lastp_q, lastp_d;
  logic [16:0]   cnt_q, cnt_d;
  logic [1:0]    full_q, full_d;
  logic [PW-1:0] len_q [2];

  logic          rbank_q, obank_q;
  logic [PW-1:0] rptr_q;
  logic [7:0]    o_data_q;
  logic          o_valid_q, o_last_q;

  logic [7:0]    mem_q [2*BANK_DEPTH];

  logic          accept, idle, over, fin, set_full, drop;
  logic          b_ovf, b_closed;
  logic [16:0]   b_cnt;
  logic [PW-1:0] b_cs, b_wp;
  logic [7:0]    b_code;
  logic          we;
  logic [PW-1:0] wa;
  logic [7:0]    wd;
  logic          ld, have, rlast, rd_free;

  function automatic logic [MW-1:0] maddr(input logic b,
                                          input logic [PW-1:0] p);
    return MW'(p) + (b ? MW'(BANK_DEPTH) : '0);
  endfunction

  assign o_ready = rst_n && (st_q == IDLE || st_q == RUN);
  assign accept  = i_valid && o_ready;
  assign o_drop  = drop;
  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;

  assign rd_free = o_valid_q && i_ready && o_last_q;
  assign ld      = !o_valid_q || i_ready;
  assign have    = full_q[rbank_q];
  assign rlast   = (rptr_q == len_q[rbank_q] - 1'b1);

  always_comb begin
    st_d     = st_q;
    wbank_d  = wbank_q;
    wptr_d   = wptr_q;
    cslot_d  = cslot_q;
    code_d   = code_q;
    closed_d = closed_q;
    ovf_d    = ovf_q;
    lastp_d  = lastp_q;
    cnt_d    = cnt_q;
    we       = 1'b0;
    wa       = wptr_q;
    wd       = 8'h00;
    fin      = 1'b0;
    set_full = 1'b0;
    drop     = 1'b0;
    idle     = (st_q == IDLE);
    b_cnt    = idle ? '0 : cnt_q;
    b_ovf    = !idle && ovf_q;
    b_closed = !idle && closed_q;
    // a closed block reopens lazily: fresh code slot at wptr
    b_cs     = idle ? '0 : (b_closed ? wptr_q : cslot_q);
    b_wp     = idle ? PW'(1) : (b_closed ? wptr_q + 1'b1 : wptr_q);
    b_code   = (idle || b_closed) ? 8'd1 : code_q;
    over     = (b_cnt + 17'd1) > 17'(MAX_FRAME);
    unique case (st_q)
      IDLE, RUN: begin
        if (accept) begin
          st_d = RUN;
          if (b_ovf || over) begin
            ovf_d = 1'b1;
            if (i_last) begin
              drop  = 1'b1;
              ovf_d = 1'b0;
              st_d  = IDLE;
            end
          end else begin
            cnt_d    = b_cnt + 17'd1;
            closed_d = 1'b0;
            we       = 1'b1;
            if (i_data != 8'h00) begin
              wa      = b_wp;
              wd      = i_data;
              wptr_d  = b_wp + 1'b1;
              cslot_d = b_cs;
              code_d  = b_code + 8'd1;
            end else begin
              wa      = b_cs;
              wd      = b_code;
              cslot_d = b_wp;
              wptr_d  = b_wp + 1'b1;
              code_d  = 8'd1;
            end
            lastp_d = i_last;
            if (code_d == 8'hFF) st_d = CLOSE255;
            else if (i_last) st_d = FINAL_CODE;
          end
        end
      end
      CLOSE255: begin
        we       = 1'b1;
        wa       = cslot_q;
        wd       = 8'hFF;
        closed_d = 1'b1;
        lastp_d  = 1'b0;
        st_d     = lastp_q ? FINAL_CODE : RUN;
      end
      FINAL_CODE: begin
        if (!closed_q) begin
          we = 1'b1;
          wa = cslot_q;
          wd = code_q;
        end
        if (APPEND_DELIM) st_d = DELIM;
        else fin = 1'b1;
      end
      DELIM: begin
        we     = 1'b1;
        wa     = wptr_q;
        wd     = 8'h00;
        wptr_d = wptr_q + 1'b1;
        fin    = 1'b1;
      end
      WAIT_BANK: begin
        if (!full_q[wbank_q]) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    if (fin) begin
      set_full = 1'b1;
      wbank_d  = ~wbank_q;
      // the reader may free the other bank this very cycle
      if (full_q[~wbank_q] && !(rd_free && obank_q != wbank_q))
        st_d = WAIT_BANK;
      else
        st_d = IDLE;
    end
  end

  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wbank_q] = 1'b1;
    if (rd_free) full_d[obank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      wbank_q  <= 1'b0;
      wptr_q   <= '0;
      cslot_q  <= '0;
      code_q   <= 8'd1;
      closed_q <= 1'b0;
      ovf_q    <= 1'b0;
      lastp_q  <= 1'b0;
      cnt_q    <= '0;
      full_q   <= '0;
      len_q[0] <= '0;
      len_q[1] <= '0;
    end else begin
      st_q     <= st_d;
      wbank_q  <= wbank_d;
      wptr_q   <= wptr_d;
      cslot_q  <= cslot_d;
      code_q   <= code_d;
      closed_q <= closed_d;
      ovf_q    <= ovf_d;
      lastp_q  <= lastp_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      if (set_full) len_q[wbank_q] <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[maddr(wbank_q, wa)] <= wd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbank_q   <= 1'b0;
      obank_q   <= 1'b0;
      rptr_q    <= '0;
      o_data_q  <= 8'h00;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else if (ld) begin
      o_valid_q <= have;
      o_last_q  <= have && rlast;
      if (have) begin
        o_data_q <= mem_q[maddr(rbank_q, rptr_q)];
        obank_q  <= rbank_q;
        if (rlast) begin
          rbank_q <= ~rbank_q;
          rptr_q  <= '0;
        end else begin
          rptr_q <= rptr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cobs_encode_pp.sv
// tb_cobs_encode_pp: directed vectors for the COBS encoder.
// Expected encodings are written out by hand (long runs built by loops).
module tb_cobs_encode_pp;

  localparam int MAXF = 260;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_last = 1'b0;
  logic       i_ready = 1'b1;
  logic       o_ready, o_valid, o_last, o_drop;
  logic [7:0] o_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drops = 0;
  int stalls = 0;
  int stall_idx = -1;
  int last_in_cyc = 0;
  bit rnd_en = 1'b0;

  logic [7:0] got[$];
  bit         gl[$];
  int         gc[$];
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  cobs_encode_pp #(.MAX_FRAME(MAXF), .APPEND_DELIM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_last(i_last),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_drop(o_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned act,
                       input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && hold_v)
      check("hold", {23'd0, o_valid, o_data}, {23'd0, 1'b1, hold_d});
    hold_v = rst_n && o_valid && !i_ready;
    hold_d = o_data;
    if (rst_n && o_valid && i_ready) begin
      got.push_back(o_data);
      gl.push_back(o_last);
      gc.push_back(cyc);
    end
    if (o_drop) drops++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    i_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1, "watchdog expired");
  end

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b[$]);
    int k;
    stalls = 0;
    stall_idx = -1;
    for (int i = 0; i < b.size(); i++) begin
      i_data  = b[i];
      i_last  = (i == b.size() - 1);
      i_valid = 1'b1;
      k = 0;
      forever begin
        @(negedge clk);
        if (o_ready) break;
        stalls++;
        stall_idx = i;
        k++;
        if (k > 600) break;
      end
      if (k > 600) check("send_timeout", 0, 1);
      last_in_cyc = cyc;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] e[$]);
    int k = 0;
    int bad = -1;
    int lp = -1;
    while (got.size() < e.size() && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_cnt"}, got.size() >= e.size(), 1);
    if (got.size() < e.size()) return;
    for (int i = 0; i < e.size(); i++) begin
      if (bad < 0 && got[i] !== e[i]) bad = i;
      if (lp < 0 && gl[i]) lp = i;
    end
    if (bad < 0) check({tag, "_data"}, got[0], e[0]);
    else check({tag, "_data"}, got[bad], e[bad]);
    check({tag, "_last"}, lp, e.size() - 1);
    for (int i = 0; i < e.size(); i++) begin
      void'(got.pop_front());
      void'(gl.pop_front());
      void'(gc.pop_front());
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] e[$];
    logic [7:0] a[$];
    logic [7:0] ea[$];
    int k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_drop", o_drop, 0);
    check("rst_data", o_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", o_ready, 1);
    gap(1);

    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    e = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send(q);
    expect_frame("t_1234", e);
    gap(2);

    q = '{8'h00};
    e = '{8'h01, 8'h01, 8'h00};
    send(q);
    expect_frame("t_zero", e);
    gap(2);

    q = '{8'h11, 8'h22, 8'h00, 8'h33};
    e = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
    send(q);
    expect_frame("t_mid0", e);
    gap(2);

    q.delete();
    e.delete();
    e.push_back(8'hFF);
    for (int i = 1; i <= 254; i++) begin
      q.push_back(8'(i));
      e.push_back(8'(i));
    end
    e.push_back(8'h00);
    send(q);
    check("t254_stalls", stalls, 0);
    expect_frame("t254", e);
    gap(2);

    q.push_back(8'hFF);
    e.delete();
    e.push_back(8'hFF);
    for (int i = 1; i <= 254; i++) e.push_back(8'(i));
    e.push_back(8'h02);
    e.push_back(8'hFF);
    e.push_back(8'h00);
    send(q);
    check("t255_stalls", stalls, 1);
    check("t255_stall_at", stall_idx, 254);
    expect_frame("t255", e);
    gap(2);

    a  = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h04, 8'h05, 8'h06,
           8'h07, 8'h08, 8'h09, 8'h0A, 8'h00, 8'h0B, 8'h0C, 8'h0D};
    ea = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h01, 8'h08, 8'h04, 8'h05,
           8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h04, 8'h0B, 8'h0C,
           8'h0D, 8'h00};
    q = '{8'h11, 8'h22, 8'h00, 8'h33};
    e = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
    send(a);
    send(q);
    k = 0;
    while (got.size() < 24 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("b2b_cnt", got.size() >= 24, 1);
    if (got.size() >= 24) begin
      check("b2b_gap", gc[18] - gc[17], 1);
      check("b2b_overlap", gc[0] < last_in_cyc, 1);
    end
    expect_frame("b2b_a", ea);
    expect_frame("b2b_b", e);
    gap(2);

    rnd_en = 1'b1;
    send(a);
    expect_frame("bp", ea);
    rnd_en = 1'b0;
    gap(4);

    q.delete();
    e.delete();
    e.push_back(8'hFF);
    for (int i = 0; i < MAXF; i++) q.push_back(8'h5A);
    for (int i = 0; i < 254; i++) e.push_back(8'h5A);
    e.push_back(8'h07);
    for (int i = 0; i < 6; i++) e.push_back(8'h5A);
    e.push_back(8'h00);
    send(q);
    expect_frame("t_max", e);
    check("t_max_nodrop", drops, 0);
    gap(2);

    q.delete();
    for (int i = 0; i < MAXF + 10; i++) q.push_back(8'h33);
    send(q);
    check("ovf_drop", drops, 1);
    q = '{8'h0A, 8'h00, 8'h0B};
    e = '{8'h02, 8'h0A, 8'h02, 8'h0B, 8'h00};
    send(q);
    expect_frame("ovf_next", e);
    check("ovf_drop_once", drops, 1);
    gap(2);

    send(a);
    k = 0;
    while (got.size() < 5 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_started", got.size() >= 5, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", o_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", o_valid, 0);
    check("rst_mid_rel", o_ready, 1);
    got.delete();
    gl.delete();
    gc.delete();
    gap(1);
    q = '{8'h00};
    e = '{8'h01, 8'h01, 8'h00};
    send(q);
    expect_frame("rst_after", e);
    gap(30);
    check("no_extra", got.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
